// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame generator and receiver:
// receiver FSM states and the even/odd parity mode constants.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/parity_acc.sv
// Single-bit running XOR accumulator with synchronous clear and enable.
// Clear has priority over enable; shared with the transmit side.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ d;
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB-first, parity, stop.
// Optional errored-frame counter enabled by `define PARITY_RX_ERRCNT_EN.
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ODD    = PAR_EVEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic              sin,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef PARITY_RX_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic            ODD_BIT  = (ODD == PAR_ODD);

  rx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              acc;
  logic              acc_clr;
  logic              acc_en;
  logic              par_bad;

  // New bit enters at the MSB so the first data bit ends up in bit 0;
  // the widened temporary keeps this valid for DATA_W = 1.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] s,
                                                 input logic b);
    logic [DATA_W:0] t;
    t = {b, s};
    return t[DATA_W:1];
  endfunction

`ifdef PARITY_RX_ERRCNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  assign acc_clr = bit_valid && (state == IDLE) && !sin;
  assign acc_en  = bit_valid && ((state == DATA) || (state == PARITY));
  assign par_bad = acc ^ ODD_BIT;

  parity_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .d     (sin),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef PARITY_RX_ERRCNT_EN
      err_cnt    <= 8'd0;
`endif
    end else begin
      data_valid <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            if (!sin) begin
              state   <= DATA;
              shreg   <= '0;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= shift_in(shreg, sin);
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) state <= PARITY;
          end
          PARITY: state <= STOP;
          STOP: begin
            // A bad stop bit is reported but the word is still delivered.
            data_out   <= shreg;
            parity_err <= par_bad;
            frame_err  <= ~sin;
            data_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
`ifdef PARITY_RX_ERRCNT_EN
            if (par_bad || !sin) err_cnt <= sat_inc(err_cnt);
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboard bench: an even-mode and an odd-mode receiver see the same line;
// directed frames push hand-computed results, a monitor pops on data_valid.
module tb_parity_frame_rx;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_valid = 1'b0;
  logic       sin = 1'b1;

  logic [7:0] dout_e, dout_o;
  logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
`ifdef PARITY_RX_ERRCNT_EN
  logic [7:0] ec_e, ec_o;
  int         exp_ec_e = 0, exp_ec_o = 0;
`endif

  exp_t q_e[$];
  exp_t q_o[$];
  int   n_tests = 0, n_fail = 0;
  int   vld_e_cnt = 0, vld_o_cnt = 0, exp_frames = 0;
  logic prev_dv_e = 1'b0, prev_dv_o = 1'b0;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(8), .ODD(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .sin(sin),
    .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e),
    .frame_err(fe_e), .busy(busy_e)
`ifdef PARITY_RX_ERRCNT_EN
    , .err_cnt(ec_e)
`endif
  );

  parity_frame_rx #(.DATA_W(8), .ODD(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .sin(sin),
    .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o),
    .frame_err(fe_o), .busy(busy_o)
`ifdef PARITY_RX_ERRCNT_EN
    , .err_cnt(ec_o)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever a receiver presents a word.
  always @(negedge clk) begin
    if (dv_e) begin
      vld_e_cnt++;
      chk("dv_e_single_cycle", prev_dv_e, 0);
      chk("busy_e_low_at_valid", busy_e, 0);
      if (q_e.size() == 0) begin
        chk("dv_e_unexpected", 1, 0);
      end else begin
        exp_t x;
        x = q_e.pop_front();
        chk("data_e", dout_e, x.data);
        chk("perr_e", pe_e, x.perr);
        chk("ferr_e", fe_e, x.ferr);
      end
    end
    if (dv_o) begin
      vld_o_cnt++;
      chk("dv_o_single_cycle", prev_dv_o, 0);
      chk("busy_o_low_at_valid", busy_o, 0);
      if (q_o.size() == 0) begin
        chk("dv_o_unexpected", 1, 0);
      end else begin
        exp_t x;
        x = q_o.pop_front();
        chk("data_o", dout_o, x.data);
        chk("perr_o", pe_o, x.perr);
        chk("ferr_o", fe_o, x.ferr);
      end
    end
    prev_dv_e = dv_e;
    prev_dv_o = dv_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    bit_valid = 1'b1;
    sin = b;
    tick();
    bit_valid = 1'b0;
    sin = 1'b1;
  endtask

  task automatic gap(input int gmax);
    if (gmax > 0) repeat ($urandom_range(gmax, 0)) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic st,
                            input int gmax, input logic exp_pe_e,
                            input logic exp_pe_o);
    q_e.push_back('{data: d, perr: exp_pe_e, ferr: ~st});
    q_o.push_back('{data: d, perr: exp_pe_o, ferr: ~st});
    exp_frames++;
`ifdef PARITY_RX_ERRCNT_EN
    if ((exp_pe_e || !st) && exp_ec_e < 255) exp_ec_e++;
    if ((exp_pe_o || !st) && exp_ec_o < 255) exp_ec_o++;
`endif
    strobe(1'b0);
    chk("busy_e_after_start", busy_e, 1);
    chk("busy_o_after_start", busy_o, 1);
    for (int i = 0; i < 8; i++) begin
      gap(gmax);
      strobe(d[i]);
    end
    gap(gmax);
    strobe(p);
    gap(gmax);
    strobe(st);
  endtask

  task automatic expect_pulses();
    tick();
    tick();
    chk("pulses_e", vld_e_cnt, exp_frames);
    chk("pulses_o", vld_o_cnt, exp_frames);
    chk("queue_e_empty", q_e.size(), 0);
    chk("queue_o_empty", q_o.size(), 0);
`ifdef PARITY_RX_ERRCNT_EN
    chk("err_cnt_e", ec_e, exp_ec_e);
    chk("err_cnt_o", ec_o, exp_ec_o);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_e"}, dout_e, 0);
    chk({tag, "_dv_e"}, dv_e, 0);
    chk({tag, "_perr_e"}, pe_e, 0);
    chk({tag, "_ferr_e"}, fe_e, 0);
    chk({tag, "_busy_e"}, busy_e, 0);
    chk({tag, "_data_o"}, dout_o, 0);
    chk({tag, "_busy_o"}, busy_o, 0);
    chk({tag, "_perr_o"}, pe_o, 0);
`ifdef PARITY_RX_ERRCNT_EN
    chk({tag, "_err_cnt_e"}, ec_e, 0);
    chk({tag, "_err_cnt_o"}, ec_o, 0);
`endif
  endtask

  initial begin
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Idle-level strobes in IDLE must not start a frame.
    strobe(1'b1);
    strobe(1'b1);
    chk("idle_ones_busy_e", busy_e, 0);

    // 0x07: three ones + parity 1 = four -> even ok, odd bad.
    send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    expect_pulses();
    // 0xA5: four ones; parity 1 -> even bad, parity 0 -> even ok.
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    expect_pulses();
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    expect_pulses();
    // 0x01 with parity 0 and random gaps: one one -> odd ok, even bad.
    send_frame(8'h01, 1'b0, 1'b1, 5, 1'b1, 1'b0);
    expect_pulses();
    // 0x3C with bad stop, then 0xF1 (parity 1) directly after the stop strobe.
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    send_frame(8'hF1, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    expect_pulses();
    chk("ferr_e_cleared", fe_e, 0);

    // Reset after the 4th data bit: partial frame discarded.
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
`ifdef PARITY_RX_ERRCNT_EN
    exp_ec_e = 0;
    exp_ec_o = 0;
`endif
    strobe(1'b1);
    strobe(1'b1);
    rst_n = 1'b1;
    tick();
    chk("midreset_no_pulse_e", vld_e_cnt, exp_frames);
    chk("midreset_no_pulse_o", vld_o_cnt, exp_frames);
    // 0x80 with parity 1: two ones -> even ok, odd bad.
    send_frame(8'h80, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    expect_pulses();

`ifdef PARITY_RX_ERRCNT_EN
    // Saturation: the even receiver sees 260 parity errors.
    for (int n = 0; n < 260; n++) send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    expect_pulses();
    chk("err_cnt_e_saturated", ec_e, 255);
    send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    expect_pulses();
    chk("err_cnt_e_holds", ec_e, 255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial receiver and parity checker for framed words produced by the team's parity generator: start bit, DATA_W data bits LSB-first, one parity bit, one stop bit. Bits arrive one per `bit_valid` strobe, already sampled and with no oversampling. The block reassembles each word, checks the received parity against the configured even/odd mode and checks the stop bit. It presents the word with error flags to downstream logic through a one-cycle valid pulse.

## Interface
- `DATA_W`, default 8: number of data bits per frame, range 1–16.
- `ODD`, default 0: parity mode. 0 selects even parity; 1 selects odd parity.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `bit_valid` input, 1 bit: `sin` holds a valid line bit in this cycle.
- `sin` input, 1 bit: serial line bit; ignored when `bit_valid` = 0.
- `data_out` output, DATA_W bits: last received word; held until the next frame completes.
- `data_valid` output, 1 bit: one-cycle pulse marking a completed frame.
- `parity_err` output, 1 bit: parity mismatch on the last frame; held like `data_out`.
- `frame_err` output, 1 bit: stop bit was 0 on the last frame; held like `data_out`.
- `busy` output, 1 bit: high in every state except IDLE.
- `err_cnt` output, 8 bits: count of errored frames. Present only with `PARITY_RX_ERRCNT_EN`.

## Operation
- FSM states:
  - **IDLE**: a strobe with `sin` = 0 (start bit) moves to DATA and clears the shift register, the bit counter and the running XOR. A strobe with `sin` = 1 is ignored.
  - **DATA**: each strobe shifts `sin` in LSB-first, XORs it into the accumulator and increments the bit counter. After the DATA_W-th strobe, moves to PARITY.
  - **PARITY**: one strobe, whose bit is XORed into the accumulator; then moves to STOP.
  - **STOP**: one strobe; then returns to IDLE.
- Completion, on the STOP strobe edge:
  - Load `data_out`.
  - `parity_err` = accumulator XOR `ODD`. In even mode the total count of ones over data plus parity must be even; in odd mode it must be odd.
  - `frame_err` = NOT `sin`.
  - Pulse `data_valid`.
- A frame with `frame_err` set is still delivered, and the FSM returns to IDLE. There is no break or resynchronisation logic.
- Strobes may be separated by any number of idle cycles. Without a strobe, the FSM and registers hold.
- The bit counter is $clog2(DATA_W+1) bits wide and never wraps within a frame.

## Timing
- Reset values:
  - `data_out` = 0, `data_valid` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0.
  - `err_cnt` = 0.
  - FSM = IDLE; shift register, bit counter and accumulator = 0.
- Latency: `data_valid`, `data_out` and both error flags become visible in the cycle after the clock edge that samples the stop bit.
- `data_valid` is high for exactly one cycle per frame.
- `busy` goes high in the cycle after the start-bit strobe. It goes low in the same cycle that `data_valid` rises.
- Back-to-back frames: a start bit strobed in the cycle directly after the stop strobe is accepted. Minimum frame length is DATA_W+3 strobes.
- Reset mid-frame: the partial frame is discarded, all outputs return to reset values immediately, and there is no `data_valid`.

## Configuration
- Macro `PARITY_RX_ERRCNT_EN`.
- Defined:
  - The `err_cnt` port exists.
  - It increments at completion when `parity_err` OR `frame_err` is set.
  - It saturates at 255 and is cleared only by reset.
- Undefined: the port and its counter logic are absent; all other behaviour is identical.

## Structure
- Shared package `parity_pkg` holds:
  - the FSM state enum `rx_state_t` (IDLE, DATA, PARITY, STOP);
  - parity mode constants `PAR_EVEN` = 0 and `PAR_ODD` = 1.
  The team's parity generator uses the same package.
- One natural sub-module, `parity_acc`: a single-bit running XOR with synchronous clear and enable, reused on the transmit side.

## Test plan
- **Even mode, good frame.** Frame 0x07, parity bit 1, stop 1, no strobe gaps → after 11 strobes: `data_out` = 0x07, `parity_err` = 0, `frame_err` = 0, one `data_valid` pulse.
- **Even mode, parity error.** Frame 0xA5 sent with parity bit 1 → `data_out` = 0xA5, `parity_err` = 1. Same frame with parity bit 0 → `parity_err` = 0.
- **Odd mode with gaps.** `ODD` = 1, frame 0x01 with parity 0, random 0–5 idle cycles between strobes → `data_out` = 0x01, `parity_err` = 0, exactly one `data_valid` pulse.
- **Bad stop bit, then back-to-back frame.** Frame 0x3C with stop bit 0 → `frame_err` = 1 and `data_valid` still pulses. An immediately following start bit is accepted; the next good frame 0xF1 (even parity bit 1) clears `frame_err`.
- **Reset mid-frame.** Assert `rst_n` = 0 after the 4th data bit → outputs at reset values, no `data_valid`. After release, frame 0x80 (parity 1) is received correctly.
- **Error counter** (`PARITY_RX_ERRCNT_EN` defined). Send 260 frames with parity errors → `err_cnt` reads 255 and holds; good frames leave it unchanged.
